// File: rtl/lc3b_types.sv
// Shared LC-3b memory-path types for the L1 line responder.
package lc3b_types;

  typedef logic [15:0]  lc3b_word;
  typedef logic [127:0] pmem_L1_bus;
  typedef logic [31:0]  lc3b_burst_word;

  localparam int LINE_BEATS  = 4;
  localparam int OFFSET_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ_BURST,
    ST_WRITE_BURST,
    ST_RESP
  } resp_state_e;

  // Clears the byte-offset bits so every burst starts on a line boundary.
  function automatic lc3b_word line_align(input lc3b_word addr);
    lc3b_word mask;
    mask = lc3b_word'((16'd1 << OFFSET_BITS) - 16'd1);
    return addr & ~mask;
  endfunction

endpackage

// File: rtl/burst_line_buffer.sv
// One-line staging buffer: whole-line load, per-beat write and per-beat read.
module burst_line_buffer #(
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH,
  parameter int IDX_BITS   = $clog2(BEATS)
) (
  input  logic                  clk,
  input  logic                  clear,
  input  logic                  load_en,
  input  logic [LINE_WIDTH-1:0] load_line,
  input  logic                  beat_we,
  input  logic [IDX_BITS-1:0]   beat_idx,
  input  logic [BEAT_WIDTH-1:0] beat_wdata,
  output logic [LINE_WIDTH-1:0] line_out,
  output logic [BEAT_WIDTH-1:0] beat_rdata
);

  // Packed so that slice k is line bits [k*BEAT_WIDTH +: BEAT_WIDTH].
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_q;
  logic [BEATS-1:0][BEAT_WIDTH-1:0] line_d;

  always_comb begin
    line_d = line_q;
    if (load_en) begin
      line_d = load_line;
    end else if (beat_we) begin
      line_d[beat_idx] = beat_wdata;
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      line_q <= '0;
    end else begin
      line_q <= line_d;
    end
  end

  assign line_out   = line_q;
  assign beat_rdata = line_q[beat_idx];

endmodule

// File: rtl/l1_line_responder.sv
// Serialises one L1 line read or writeback into a fixed-length beat burst
// and answers the cache with a single-cycle response.
module l1_line_responder
  import lc3b_types::*;
#(
  parameter int LINE_WIDTH = 128,
  parameter int BEAT_WIDTH = 32,
  parameter int BEATS      = LINE_WIDTH / BEAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           pmem_address,
  input  logic                  pmem_read,
  input  logic                  pmem_write,
  input  logic [LINE_WIDTH-1:0] pmem_wdata,
  output logic [LINE_WIDTH-1:0] pmem_rdata,
  output logic                  pmem_resp,
  output logic [15:0]           burst_address,
  output logic                  burst_read,
  output logic                  burst_write,
  output logic [BEAT_WIDTH-1:0] burst_wdata,
  input  logic [BEAT_WIDTH-1:0] burst_rdata,
  input  logic                  burst_ack
);

  localparam int IDX_BITS   = $clog2(BEATS);
  localparam int BEAT_SHIFT = $clog2(BEAT_WIDTH / 8);
  localparam logic [IDX_BITS-1:0] LAST_BEAT = IDX_BITS'(BEATS - 1);

  resp_state_e          state_q, state_d;
  logic [IDX_BITS-1:0]  cnt_q, cnt_d;
  lc3b_word             addr_q, addr_d;
  logic                 buf_load;
  logic                 buf_we;
  logic [BEAT_WIDTH-1:0] buf_beat;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    buf_load = 1'b0;
    buf_we   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // A writeback takes priority over a read presented in the same cycle.
        if (pmem_write) begin
          addr_d   = line_align(pmem_address);
          buf_load = 1'b1;
          state_d  = ST_WRITE_BURST;
        end else if (pmem_read) begin
          addr_d  = line_align(pmem_address);
          state_d = ST_READ_BURST;
        end
      end
      ST_READ_BURST: begin
        if (burst_ack) begin
          buf_we = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_WRITE_BURST: begin
        if (burst_ack) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == LAST_BEAT) begin
            state_d = ST_RESP;
          end
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
    end
  end

  burst_line_buffer #(
    .LINE_WIDTH (LINE_WIDTH),
    .BEAT_WIDTH (BEAT_WIDTH),
    .BEATS      (BEATS),
    .IDX_BITS   (IDX_BITS)
  ) u_line_buf (
    .clk        (clk),
    .clear      (reset),
    .load_en    (buf_load),
    .load_line  (pmem_wdata),
    .beat_we    (buf_we),
    .beat_idx   (cnt_q),
    .beat_wdata (burst_rdata),
    .line_out   (pmem_rdata),
    .beat_rdata (buf_beat)
  );

  // Strobes and response decode straight from the registered state.
  assign burst_read    = (state_q == ST_READ_BURST);
  assign burst_write   = (state_q == ST_WRITE_BURST);
  assign pmem_resp     = (state_q == ST_RESP);
  assign burst_wdata   = burst_write ? buf_beat : '0;
  assign burst_address = addr_q + (lc3b_word'(cnt_q) << BEAT_SHIFT);

endmodule

// File: tb/tb_l1_line_responder.sv
// Directed bench for l1_line_responder: table of line transactions plus
// hand-written reset and stray-ack sequences.
module tb_l1_line_responder;

  logic         clk = 1'b0;
  logic         reset;
  logic [15:0]  pmem_address;
  logic         pmem_read;
  logic         pmem_write;
  logic [127:0] pmem_wdata;
  logic [127:0] pmem_rdata;
  logic         pmem_resp;
  logic [15:0]  burst_address;
  logic         burst_read;
  logic         burst_write;
  logic [31:0]  burst_wdata;
  logic [31:0]  burst_rdata;
  logic         burst_ack;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  l1_line_responder dut (
    .clk           (clk),
    .reset         (reset),
    .pmem_address  (pmem_address),
    .pmem_read     (pmem_read),
    .pmem_write    (pmem_write),
    .pmem_wdata    (pmem_wdata),
    .pmem_rdata    (pmem_rdata),
    .pmem_resp     (pmem_resp),
    .burst_address (burst_address),
    .burst_read    (burst_read),
    .burst_write   (burst_write),
    .burst_wdata   (burst_wdata),
    .burst_rdata   (burst_rdata),
    .burst_ack     (burst_ack)
  );

  typedef struct {
    string        name;
    logic         rd;
    logic         wr;
    logic [15:0]  addr;
    logic [127:0] line;     // write data, or the beats memory returns on a read
    int           gap;      // idle cycles before each ack
    logic         exp_wr;   // expected burst type
    logic [15:0]  exp_base; // expected first beat address
    int           exp_lat;  // cycles from request to pmem_resp
  } vec_t;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end else begin
      $display("ok   %s: %h", name, act);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int  beat;
    int  stall;
    bit  done;
    int  resp_cnt;
    beat     = 0;
    stall    = 0;
    done     = 1'b0;
    resp_cnt = 0;
    @(negedge clk);
    pmem_read    = v.rd;
    pmem_write   = v.wr;
    pmem_address = v.addr;
    pmem_wdata   = v.wr ? v.line : ~v.line;
    for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
      @(negedge clk);
      burst_ack = 1'b0;
      if (pmem_resp) begin
        resp_cnt++;
        check({v.name, " resp_latency"}, 128'(cyc), 128'(v.exp_lat));
        check({v.name, " beats"}, 128'(beat), 128'(4));
        check({v.name, " rdata"}, pmem_rdata, v.line);
        check({v.name, " strobes_in_resp"}, 128'({burst_read, burst_write}), 128'(0));
        done = 1'b1;
      end else if (burst_read || burst_write) begin
        check({v.name, " strobe_type"}, 128'({burst_read, burst_write}),
              128'(v.exp_wr ? 2'b01 : 2'b10));
        check({v.name, " beat_addr"}, 128'(burst_address),
              128'(v.exp_base + 16'((beat & 3) * 4)));
        if (v.exp_wr)
          check({v.name, " beat_wdata"}, 128'(burst_wdata), 128'(v.line[(beat & 3)*32 +: 32]));
        if (stall == v.gap) begin
          burst_ack   = 1'b1;
          burst_rdata = v.line[(beat & 3)*32 +: 32];
          beat++;
          stall = 0;
        end else begin
          burst_rdata = $urandom;
          stall++;
        end
      end else begin
        check({v.name, " busy"}, 128'(burst_read | burst_write | pmem_resp), 128'(1));
      end
    end
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s timeout: no pmem_resp within 200 cycles", v.name);
    end
    // Request stays high through the RESP cycle and drops in the next one.
    @(negedge clk);
    burst_ack  = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    check({v.name, " idle_after_resp"}, 128'({burst_read, burst_write, pmem_resp}), 128'(0));
    check({v.name, " rdata_hold"}, pmem_rdata, v.line);
    check({v.name, " resp_count"}, 128'(resp_cnt), 128'(1));
  endtask

  vec_t vecs[4];
  vec_t again;

  initial begin
    vecs[0] = '{"read_ack", 1'b1, 1'b0, 16'h1238,
                128'h44444444_33333333_22222222_11111111, 0, 1'b0, 16'h1230, 5};
    vecs[1] = '{"write_stall", 1'b0, 1'b1, 16'h2000,
                128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 2, 1'b1, 16'h2000, 13};
    vecs[2] = '{"rd_wr_both", 1'b1, 1'b1, 16'h3000,
                128'h0F0F0F0F_12345678_9ABCDEF0_CAFEBABE, 0, 1'b1, 16'h3000, 5};
    vecs[3] = '{"read_gap1", 1'b1, 1'b0, 16'h400F,
                128'hA5A5A5A5_5A5A5A5A_DEADBEEF_01234567, 1, 1'b0, 16'h4000, 9};
    again   = '{"read_after", 1'b1, 1'b0, 16'h6004,
                128'h87654321_FEDCBA98_13579BDF_2468ACE0, 0, 1'b0, 16'h6000, 5};

    reset        = 1'b1;
    pmem_address = '0;
    pmem_read    = 1'b0;
    pmem_write   = 1'b0;
    pmem_wdata   = '0;
    burst_rdata  = '0;
    burst_ack    = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_rdata", pmem_rdata, 128'(0));
    check("reset_ctrl", 128'({pmem_resp, burst_read, burst_write}), 128'(0));
    check("reset_addr", 128'(burst_address), 128'(0));
    check("reset_wdata", 128'(burst_wdata), 128'(0));
    reset = 1'b0;

    for (int i = 0; i < 4; i++) run_txn(vecs[i]);

    // Stray acks while idle must neither start a burst nor advance the counter.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      burst_ack   = 1'b1;
      burst_rdata = 32'hFFFF_FFFF;
      check("stray_ack_idle", 128'({pmem_resp, burst_read, burst_write}), 128'(0));
    end
    @(negedge clk);
    burst_ack = 1'b0;
    check("stray_ack_rdata", pmem_rdata, vecs[3].line);
    run_txn(vecs[0]);

    // Reset after the second read ack abandons the burst silently.
    @(negedge clk);
    pmem_read    = 1'b1;
    pmem_address = 16'h5008;
    @(negedge clk);
    burst_ack   = 1'b1;
    burst_rdata = 32'h5555_0000;
    @(negedge clk);
    burst_rdata = 32'h5555_1111;
    @(negedge clk);
    burst_ack = 1'b0;
    check("midburst_addr", 128'(burst_address), 128'(16'h5008));
    reset     = 1'b1;
    pmem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    check("midreset_strobes", 128'({pmem_resp, burst_read, burst_write}), 128'(0));
    check("midreset_rdata", pmem_rdata, 128'(0));
    check("midreset_addr", 128'(burst_address), 128'(0));
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("midreset_no_resp", 128'(pmem_resp), 128'(0));
    end
    run_txn(again);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
